// File: rtl/cpu4_pkg.sv
// ----------------------------------------------------------------------------
// cpu4_pkg
// Shared widths, opcode constants and the fetch-state encoding for the 4-bit
// CPU fetch slice.
//
// Optional feature macro: FETCH_HALT_EN. When it is defined, the fetch FSM
// gains a HALT state. When it is undefined, the HALT state does not exist.
// ----------------------------------------------------------------------------
package cpu4_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 8;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

`ifdef FETCH_HALT_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1
    } fetch_state_t;
`endif

    // The opcode is the top nibble of the instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_if
// Instruction-memory read channel between the fetch unit and the memory.
//
//   imem_req  : fetch -> mem, read request
//   imem_addr : fetch -> mem, read address (the current pc)
//   imem_ack  : mem -> fetch, read data valid this cycle
//   imem_data : mem -> fetch, instruction word
//
// Modports:
//   master : the fetch unit
//   slave  : the memory model or memory
// ----------------------------------------------------------------------------
interface pc_fetch_if;
    import cpu4_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/pc_fetch_pc_reg.sv
// ----------------------------------------------------------------------------
// pc_reg
// Holds the 4-bit program counter.
//
//   clock     : system clock (rising edge)
//   reset_n   : asynchronous active-low reset, forces pc to 0
//   i_load    : load i_load_pc (takes priority over i_inc)
//   i_load_pc : redirect target
//   i_inc     : advance pc by one, modulo 16
//   o_pc      : current pc
//   o_next_pc : pc + 1 modulo 16, combinational
// ----------------------------------------------------------------------------
module pc_reg
    import cpu4_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_plus1;

    // Natural 4-bit overflow gives the 15 -> 0 wrap.
    assign w_pc_plus1 = r_pc + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= w_pc_plus1;
        end
    end

    assign o_pc      = r_pc;
    assign o_next_pc = w_pc_plus1;

endmodule

// File: rtl/pc_fetch.sv
// ----------------------------------------------------------------------------
// pc_fetch
// Instruction fetch stage. It fetches one word from instruction memory and
// presents it to decode. It then holds the word until decode consumes it.
// A jump redirects the pc. A jump always has priority over a memory
// acknowledge and over a stall.
//
// Ports:
//   clock       : system clock (rising edge)
//   reset_n     : asynchronous active-low reset
//   jump        : redirect request
//   branch_pc   : redirect target, sampled when jump=1
//   stall       : decode not ready; holds the presented instruction
//   imem        : instruction-memory channel (pc_fetch_if.master)
//   pc          : current fetch address
//   next_pc     : pc + 1 modulo 16, combinational
//   instr       : instruction register to decode
//   instr_valid : instr holds an unconsumed instruction
//   halted      : fetch stopped on a HALT opcode
//
// Optional feature macro: FETCH_HALT_EN.
//   - Defined: an acknowledged word with opcode 4'hF parks the FSM in HALT
//     until reset.
//   - Undefined: opcode 4'hF is fetched as a normal instruction, and
//     halted is tied to 0.
// ----------------------------------------------------------------------------
module pc_fetch
    import cpu4_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               jump,
    input  logic [PC_W-1:0]    branch_pc,
    input  logic               stall,
    pc_fetch_if.master         imem,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    next_pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               halted
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic               w_pc_load;
    logic               w_pc_inc;
    logic               w_instr_load;
    logic               w_is_halt;
    logic [PC_W-1:0]    w_pc;
    logic [PC_W-1:0]    w_next_pc;

    pc_reg u_pc_reg (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_pc_load),
        .i_load_pc (branch_pc),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc),
        .o_next_pc (w_next_pc)
    );

`ifdef FETCH_HALT_EN
    assign w_is_halt = (opcode_of(imem.imem_data) == OPC_HALT);
`else
    assign w_is_halt = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_instr_load = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // A jump wins over an ack in the same cycle. The acked
                // word is dropped, and fetch restarts at the target.
                if (jump) begin
                    w_pc_load = 1'b1;
                end else if (imem.imem_ack) begin
                    if (w_is_halt) begin
`ifdef FETCH_HALT_EN
                        // pc and instr stay frozen at the HALT word's address.
                        w_state_next = ST_HALT;
`endif
                    end else begin
                        w_instr_load = 1'b1;
                        w_pc_inc     = 1'b1;
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (jump) begin
                    w_pc_load    = 1'b1;
                    w_state_next = ST_FETCH;
                end else if (!stall) begin
                    w_state_next = ST_FETCH;
                end
            end
`ifdef FETCH_HALT_EN
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
`endif
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // instr keeps its last value after it is consumed; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= '0;
        end else if (w_instr_load) begin
            r_instr <= imem.imem_data;
        end
    end

    assign imem.imem_req  = (r_state == ST_FETCH);
    assign imem.imem_addr = w_pc;

    assign pc          = w_pc;
    assign next_pc     = w_next_pc;
    assign instr       = r_instr;
    // The instruction is valid exactly while it is parked in HOLD.
    assign instr_valid = (r_state == ST_HOLD);

`ifdef FETCH_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: jump  in  1  redirect request from the jump/branch logic.
REQ-004 SHALL have port: branch_pc  in  4  redirect target, sampled when jump=1.
REQ-005 SHALL have port: stall  in  1  decode not ready; holds the presented instruction.
REQ-006 SHALL have port: imem_req  out  1  instruction-memory read request.
REQ-007 SHALL have port: imem_addr  out  4  read address; equals pc.
REQ-008 SHALL have port: imem_ack  in  1  memory read data valid this cycle.
REQ-009 SHALL have port: imem_data  in  8  instruction word; opcode = bits [7:4].
REQ-010 SHALL have port: pc  out  4  current fetch address.
REQ-011 SHALL have port: next_pc  out  4  pc+1 mod 16, combinational; feeds the PC mux nextPC input.
REQ-012 SHALL have port: instr  out  8  instruction register to decode.
REQ-013 SHALL have port: instr_valid  out  1  instr holds an unconsumed instruction.
REQ-014 SHALL have port: halted  out  1  fetch stopped on HALT opcode.

Function
REQ-015 SHALL implement FSM states FETCH, HOLD, HALT; imem_req=1 only in FETCH.
REQ-016 FETCH: imem_addr=pc; on imem_ack=1 and jump=0 SHALL load instr<=imem_data, set instr_valid, set pc<=pc+1, and go to HOLD.
REQ-017 FETCH without imem_ack SHALL hold pc and state, with req held high.
REQ-018 HOLD: instr_valid=1; stall=0 at the edge consumes the instruction: instr_valid<=0, go to FETCH. stall=1 SHALL hold instr, instr_valid and pc unchanged.
REQ-019 stall SHALL have no effect in FETCH.
REQ-020 jump=1 in FETCH or HOLD SHALL set pc<=branch_pc, clear instr_valid, and go to FETCH; jump takes priority over imem_ack and stall in the same cycle, and the acknowledged data SHALL be discarded.
REQ-021 pc arithmetic SHALL be 4-bit modulo: 15+1=0; next_pc at pc=15 is 0.
REQ-022 Best-case throughput SHALL be one instruction per 2 cycles with imem_ack tied high.
REQ-023 instr SHALL retain its last value when instr_valid=0.

Reset
REQ-024 reset_n=0 SHALL asynchronously force pc=0, instr=8'h00, instr_valid=0, halted=0, state=FETCH.
REQ-025 Reset mid-operation SHALL abandon any outstanding request and discard any held instruction; fetch restarts at address 0 on the first edge after release.

Configuration
REQ-026 Macro FETCH_HALT_EN defined: an acknowledged word with opcode 4'hF SHALL leave pc and instr unchanged, keep instr_valid=0, and go to HALT; jump and ack SHALL not cause HALT to be left.
REQ-027 FETCH_HALT_EN defined: HALT SHALL drive imem_req=0 and halted=1 until reset.
REQ-028 FETCH_HALT_EN undefined: opcode 4'hF SHALL be fetched as a normal instruction, the HALT state SHALL be absent, and halted SHALL be tied 0.

Structure
REQ-029 Shared package cpu4_pkg SHALL hold PC_W=4, INSTR_W=8, OPC_HALT=4'hF, and the fetch-state enum.
REQ-030 Sub-module pc_reg SHALL hold the 4-bit pc with async active-low reset, load and increment enables, and the next_pc output; the FSM SHALL stay in pc_fetch.

Verification
REQ-031 Sequential fetch: imem_ack=1, imem_data=8'h12, stall=0 from reset -> instr=8'h12 valid at cycle 2; pc 0->1->2 every 2 cycles.
REQ-032 Stall: valid instr 8'h34 at pc=3, stall=1 for 3 cycles -> instr, instr_valid=1 and pc=3 held; stall=0 -> FETCH at pc=3.
REQ-033 Jump vs ack: in FETCH at pc=2, jump=1, branch_pc=5, imem_ack=1 in the same cycle -> instr_valid stays 0; next imem_addr=5.
REQ-034 Wrap: pc=15 fetch acked -> pc=0; next_pc=1.
REQ-035 HALT with FETCH_HALT_EN: imem_data=8'hF0 acked at pc=4 -> halted=1, imem_req=0, pc=4; jump=1 is ignored. Without the macro -> instr=8'hF0, pc=5.
REQ-036 Async reset: assert reset_n=0 mid-HOLD at pc=9 -> immediately pc=0 and instr_valid=0, without waiting for a clock edge.
